// File: rtl/booth_mac_stream_pkg.sv
// Shared defaults and saturating-add helpers for the streaming Booth MAC.
package booth_mac_stream_pkg;

    localparam int WIDTH_DEF = 10;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;
    localparam int SUM_W     = 64;

    function automatic logic signed [SUM_W-1:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SUM_W-1:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic add_ovf(
        input logic signed [SUM_W-1:0] x,
        input logic signed [SUM_W-1:0] y,
        input int                      w
    );
        logic signed [SUM_W-1:0] s;
        s = x + y;
        return (s > sat_max(w)) || (s < sat_min(w));
    endfunction

    // Wide add then clamp to a w-bit signed range.
    function automatic logic signed [SUM_W-1:0] sat_add(
        input logic signed [SUM_W-1:0] x,
        input logic signed [SUM_W-1:0] y,
        input int                      w
    );
        logic signed [SUM_W-1:0] s;
        s = x + y;
        if (s > sat_max(w)) begin
            return sat_max(w);
        end
        if (s < sat_min(w)) begin
            return sat_min(w);
        end
        return s;
    endfunction

endpackage

// File: rtl/Multi_Booth_signed_even.sv
// Combinational radix-4 Booth signed multiplier; width must be even.
module Multi_Booth_signed_even #(
    parameter int width = 10
) (
    input  logic signed [width-1:0]   a,
    input  logic signed [width-1:0]   b,
    output logic signed [2*width-1:0] p
);

    logic        [width:0]       bx;
    logic signed [2*width-1:0]   ax;
    logic signed [2*width-1:0]   pp;
    logic signed [2*width-1:0]   sum;

    always_comb begin
        bx  = {b, 1'b0};
        ax  = (2*width)'(a);
        sum = '0;
        pp  = '0;
        for (int i = 0; i < width / 2; i++) begin
            pp = '0;
            unique case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ax;
                3'b011:         pp = ax <<< 1;
                3'b100:         pp = -(ax <<< 1);
                3'b101, 3'b110: pp = -ax;
                default:        pp = '0;
            endcase
            sum = sum + (pp <<< (2 * i));
        end
        p = sum;
    end

endmodule

// File: rtl/booth_mac_stream.sv
// Streaming signed dot-product: operand reg, Booth product reg, saturating
// accumulator and a held result register behind a valid/ready output.
module booth_mac_stream
    import booth_mac_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat
);

    logic                      adv;
    logic                      v0;
    logic                      v1;
    logic                      last0;
    logic                      last1;
    logic signed [WIDTH-1:0]   a_q;
    logic signed [WIDTH-1:0]   b_q;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] p_q;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          cnt_nxt;
    logic                      sat;
    logic                      ovf;
    logic                      done;

    Multi_Booth_signed_even #(
        .width(WIDTH)
    ) u_mult (
        .a(a_q),
        .b(b_q),
        .p(prod)
    );

    // Only a finished vector blocked by an unread result stalls the pipe.
    assign adv      = !(v1 && last1 && out_valid && !out_ready);
    assign in_ready = adv;
    assign done     = adv && v1 && last1;

    always_comb begin
        sum     = ACC_W'(sat_add(SUM_W'(acc), SUM_W'(p_q), ACC_W));
        ovf     = add_ovf(SUM_W'(acc), SUM_W'(p_q), ACC_W);
        cnt_nxt = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else if (adv) begin
            if (in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            p_q <= prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            last0     <= 1'b0;
            last1     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (clr) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            last0     <= 1'b0;
            last1     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (adv) begin
                v0    <= in_valid;
                v1    <= v0;
                last1 <= last0;
                if (in_valid) begin
                    last0 <= in_last;
                end
                if (v1 && last1) begin
                    out_acc   <= sum;
                    out_count <= cnt_nxt;
                    out_sat   <= sat | ovf;
                    acc       <= '0;
                    count     <= '0;
                    sat       <= 1'b0;
                end else if (v1) begin
                    acc   <= sum;
                    count <= cnt_nxt;
                    sat   <= sat | ovf;
                end
            end
            if (done) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_mac_stream.sv
// Self-checking bench: directed scenarios plus random streams checked
// against a saturating dot-product reference model.
module tb_booth_mac_stream;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;
    logic signed [9:0]  in_a;
    logic signed [9:0]  in_b;

    logic               in_ready;
    logic               out_valid;
    logic signed [23:0] out_acc;
    logic [7:0]         out_count;
    logic               out_sat;

    logic               in_ready20;
    logic               out_valid20;
    logic signed [19:0] out_acc20;
    logic [7:0]         out_count20;
    logic               out_sat20;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint a24;
        longint a20;
        int     cnt;
        bit     s24;
        bit     s20;
    } exp_t;

    exp_t   q[$];
    exp_t   e;
    bit     got;
    bit     in_fire;
    bit     out_fire;
    longint m24;
    longint m20;
    int     mcnt;
    bit     ms24;
    bit     ms20;

    booth_mac_stream dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
    );

    booth_mac_stream #(.ACC_W(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready20),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid20), .out_ready(out_ready),
        .out_acc(out_acc20), .out_count(out_count20), .out_sat(out_sat20)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint s, input int w, inout bit sat);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (s > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (s < lo) begin
            sat = 1'b1;
            return lo;
        end
        return s;
    endfunction

    task automatic model_reset();
        m24 = 0; m20 = 0; mcnt = 0; ms24 = 0; ms20 = 0;
        q.delete();
    endtask

    task automatic model_accept(input int a, input int b, input bit l);
        longint p;
        exp_t   x;
        p = longint'(a) * longint'(b);
        m24 = clamp(m24 + p, 24, ms24);
        m20 = clamp(m20 + p, 20, ms20);
        if (mcnt < 255) mcnt++;
        if (l) begin
            x.a24 = m24; x.a20 = m20; x.cnt = mcnt;
            x.s24 = ms24; x.s20 = ms20;
            q.push_back(x);
            m24 = 0; m20 = 0; mcnt = 0; ms24 = 0; ms20 = 0;
        end
    endtask

    // Drive one cycle at the falling edge; handshakes are judged just after.
    task automatic cycle(input bit v, input int a, input int b, input bit l, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_a      = 10'(a);
        in_b      = 10'(b);
        in_last   = l;
        out_ready = r;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        got = 1'b0;
        if (out_fire && q.size() > 0) begin
            e   = q.pop_front();
            got = 1'b1;
        end
        if (in_fire) model_accept(int'(in_a), int'(in_b), in_last);
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle(0, 0, 0, 0, 1);
            ok = out_fire;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle(0, 0, 0, 0, 0);
            ok = out_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; clr = 0; in_valid = 0; in_last = 0;
        out_ready = 0; in_a = 0; in_b = 0;
        model_reset();
        #12;
        checks++;
        if ({out_valid, out_acc, out_count, out_sat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b acc=%0d cnt=%0d sat=%b want all 0",
                     out_valid, out_acc, out_count, out_sat);
        end
        #11 rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        cycle(1, 3, -4, 1, 0);
        checks++;
        if (!in_fire) begin
            errors++;
            $display("FAIL single_accept: got in_ready=%b want 1", in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL single_latency_%0d: got out_valid=%b want %b",
                         k, out_valid, k == 3);
            end
        end
        checks++;
        if (out_acc !== -24'sd12 || out_count !== 8'd1 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got acc=%0d cnt=%0d sat=%b want -12 1 0",
                     out_acc, out_count, out_sat);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_vector();
        int a[4] = '{1, -5, -512, 100};
        int b[4] = '{2, 7, -512, -3};
        int acc_n = 0;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            cycle(1, a[k], b[k], k == 3, 1);
            if (in_fire) acc_n++;
        end
        checks++;
        if (acc_n != 4) begin
            errors++;
            $display("FAIL vector_no_bubble: got %0d accepts want 4", acc_n);
        end
        wait_out(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vector_timeout: got no result want one");
        end else if (out_acc !== 24'sd2 - 24'sd35 + 24'sd262144 - 24'sd300 ||
                     out_count !== 8'd4 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL vector_result: got acc=%0d cnt=%0d sat=%b want %0d 4 0",
                     out_acc, out_count, out_sat, 2 - 35 + 262144 - 300);
        end
    endtask

    task automatic test_back_to_back();
        int a[4] = '{10, -3, 5, -100};
        int b[4] = '{20, 7, 5, 4};
        int k = 0;
        int n_out = 0;
        bit stall = 0;
        bit held_ok = 1;
        for (int t = 0; t < 30 && k < 4; t++) begin
            cycle(1, a[k], b[k], k == 1 || k == 3, 0);
            if (!in_ready) stall = 1;
            if (in_fire) k++;
        end
        for (int t = 0; t < 5; t++) begin
            cycle(0, 0, 0, 0, 0);
            if (!in_ready) stall = 1;
            if (out_valid !== 1'b1 || out_acc !== 24'sd179) held_ok = 0;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 4", k);
        end
        checks++;
        if (!stall || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got stall=%b in_ready=%b want 1 0", stall, in_ready);
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL b2b_hold: got acc=%0d v=%b want 179 1", out_acc, out_valid);
        end
        for (int t = 0; t < 10 && n_out < 2; t++) begin
            cycle(0, 0, 0, 0, 1);
            if (out_fire) begin
                n_out++;
                checks++;
                if (out_acc !== ((n_out == 1) ? 24'sd179 : -24'sd375) ||
                    out_count !== 8'd2) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got acc=%0d cnt=%0d want %0d 2",
                             n_out, out_acc, out_count, (n_out == 1) ? 179 : -375);
                end
            end
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (n_out != 2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results v=%b want 2 0", n_out, out_valid);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        for (int k = 0; k < 3; k++) cycle(1, 511, 511, k == 2, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_acc20 !== 20'sd524287 || out_sat20 !== 1'b1 ||
            out_count20 !== 8'd3) begin
            errors++;
            $display("FAIL sat20_result: got acc=%0d sat=%b cnt=%0d want 524287 1 3",
                     out_acc20, out_sat20, out_count20);
        end
        checks++;
        if (!ok || out_acc !== 24'sd783363 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat24_result: got acc=%0d sat=%b want 783363 0",
                     out_acc, out_sat);
        end
        cycle(1, 1, 1, 1, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_acc20 !== 20'sd1 || out_sat20 !== 1'b0) begin
            errors++;
            $display("FAIL sat20_next: got acc=%0d sat=%b want 1 0", out_acc20, out_sat20);
        end
    endtask

    task automatic test_clr();
        bit ok;
        cycle(1, 7, 1, 1, 0);
        wait_valid(ok);
        cycle(1, 3, 3, 0, 0);
        cycle(1, 4, 4, 0, 0);
        @(negedge clk);
        in_valid = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        model_reset();
        #1;
        checks++;
        if (!ok || out_valid !== 1'b0 || out_acc !== '0 || out_count !== '0) begin
            errors++;
            $display("FAIL clr_flush: got v=%b acc=%0d cnt=%0d want 0 0 0",
                     out_valid, out_acc, out_count);
        end
        cycle(1, 2, 2, 1, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_acc !== 24'sd4 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_next: got acc=%0d cnt=%0d want 4 1", out_acc, out_count);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        cycle(1, 9, 9, 1, 0);
        wait_valid(ok);
        cycle(1, 6, 6, 0, 0);
        cycle(1, 6, 6, 0, 0);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if (!ok || {out_valid, out_acc, out_count, out_sat} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: got v=%b acc=%0d cnt=%0d sat=%b want all 0",
                     out_valid, out_acc, out_count, out_sat);
        end
        #4 rst_n = 1;
        model_reset();
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_ready: got %b want 1", in_ready);
        end
        cycle(1, 2, 3, 1, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_acc !== 24'sd6 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL arst_next: got acc=%0d cnt=%0d want 6 1", out_acc, out_count);
        end
    endtask

    task automatic check_fire(input string tag);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_unexpected: got result acc=%0d want none", tag, out_acc);
        end else if (out_acc !== 24'(e.a24) || out_acc20 !== 20'(e.a20) ||
                     out_count !== 8'(e.cnt) || out_sat !== e.s24 ||
                     out_sat20 !== e.s20) begin
            errors++;
            $display("FAIL %s_result: got %0d/%0d cnt=%0d sat=%b/%b want %0d/%0d cnt=%0d sat=%b/%b",
                     tag, out_acc, out_acc20, out_count, out_sat, out_sat20,
                     e.a24, e.a20, e.cnt, e.s24, e.s20);
        end
    endtask

    task automatic test_long();
        int k = 0;
        bit ok;
        for (int t = 0; t < 400 && k < 300; t++) begin
            cycle(1, int'($urandom_range(0, 1023)) - 512,
                  int'($urandom_range(0, 1023)) - 512, k == 299, 1);
            if (in_fire) k++;
        end
        wait_out(ok);
        check_fire("long");
        checks++;
        if (out_count !== 8'd255) begin
            errors++;
            $display("FAIL long_sticky: got cnt=%0d want 255", out_count);
        end
    endtask

    task automatic test_random();
        bit               hold = 0;
        logic signed [23:0] prev = '0;
        bit               fin = 0;
        for (int t = 0; t < 600; t++) begin
            int a;
            a = ($urandom_range(0, 7) == 0) ? -512 : int'($urandom_range(0, 1023)) - 512;
            cycle($urandom_range(0, 99) < 70, a, int'($urandom_range(0, 1023)) - 512,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 60);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_acc !== prev) begin
                    errors++;
                    $display("FAIL rand_stable: got v=%b acc=%0d want 1 %0d",
                             out_valid, out_acc, prev);
                end
            end
            if (out_fire) check_fire("rand");
            hold = out_valid && !out_ready;
            prev = out_acc;
        end
        for (int t = 0; t < 20 && !fin; t++) begin
            cycle(1, 1, 1, 1, 1);
            if (out_fire) check_fire("rand");
            fin = in_fire;
        end
        for (int t = 0; t < 30; t++) begin
            cycle(0, 0, 0, 0, 1);
            if (out_fire) check_fire("drain");
        end
        checks++;
        if (q.size() != 0 || !fin) begin
            errors++;
            $display("FAIL rand_drain: got %0d pending fin=%b want 0 1", q.size(), fin);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_vector();
        test_back_to_back();
        test_saturate();
        test_clr();
        test_async_reset();
        test_long();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
